// File: rtl/mbo53_pkg.sv
// Shared types for the ADC block arbiter: FSM state encoding and header byte layout.
package mbo53_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_HDR,
        ST_STREAM,
        ST_DONE
    } state_t;

    localparam int HDR_LEN   = 4;
    localparam int HDR_CNT_W = 2;

    // Header beats: channel nibble, then sequence number MSB first.
    function automatic logic [7:0] hdr_byte(input logic [HDR_CNT_W-1:0] idx,
                                            input logic [3:0]           ch,
                                            input logic [23:0]          seq);
        case (idx)
            2'd0:    hdr_byte = {4'h0, ch};
            2'd1:    hdr_byte = seq[23:16];
            2'd2:    hdr_byte = seq[15:8];
            default: hdr_byte = seq[7:0];
        endcase
    endfunction

endpackage

// File: rtl/adc_block_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo N_CH.
module rr_arbiter
    import mbo53_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int CH_W = 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_any
);

    int scan;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = 0;
        for (int i = 0; i < N_CH; i++) begin
            scan = int'(ptr) + i;
            if (scan >= N_CH) scan = scan - N_CH;
            if (!grant_any && req[scan]) begin
                grant_any   = 1'b1;
                grant[scan] = 1'b1;
                grant_idx   = CH_W'(scan);
            end
        end
    end

endmodule

// File: rtl/adc_block_arbiter.sv
// N-channel ADC FIFO to packet-stream block arbiter, one BLOCK_BYTES block per grant.
// Optional 4-beat channel/sequence header when ARB_HEADER_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | wait for any enabled channel holding a full block
// ST_ARB    | round-robin grant, latch channel, advance pointer
// ST_HDR    | emit 4 header beats (ARB_HEADER_EN builds only)
// ST_STREAM | read BLOCK_BYTES bytes from the granted FIFO, stall on ready/empty
// ST_DONE   | final beat leaves the output register, clear byte counter
module adc_block_arbiter
    import mbo53_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DATA_W      = 8,
    parameter int BLOCK_BYTES = 256,
    parameter int SEQ_W       = 24,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        ch_enable,
    input  logic [N_CH-1:0]        ch_block_rdy,
    input  logic [N_CH-1:0]        ch_rdempty,
    input  logic [N_CH*DATA_W-1:0] ch_dout,
    output logic [N_CH-1:0]        ch_rdreq,
    input  logic                   pkt_ready,
    output logic                   pkt_valid,
    output logic [DATA_W-1:0]      pkt_data,
    output logic                   pkt_sop,
    output logic                   pkt_eop,
    output logic [CH_W-1:0]        pkt_ch,
    output logic                   underrun_err
);

    localparam int              CNT_W = $clog2(BLOCK_BYTES) + 1;
    localparam logic [CNT_W-1:0] BLK  = CNT_W'(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BYTES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CH_W-1:0]   rr_ptr, ch_q, grant_idx;
    logic [N_CH-1:0]   req, grant, sel_q;
    logic              grant_any, rd_fire, last_rd;
    logic              beat_q, sop_q, eop_q, underrun_q;

    assign req = ch_block_rdy & ch_enable;

    rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign rd_fire  = (state_q == ST_STREAM) && pkt_ready && !ch_rdempty[ch_q] && (rd_cnt < BLK);
    assign last_rd  = rd_fire && (rd_cnt == LAST);
    assign ch_rdreq = rd_fire ? sel_q : '0;

`ifdef ARB_HEADER_EN
    logic [HDR_CNT_W-1:0] hdr_cnt;
    logic [7:0]           hdr_q;
    logic                 hdr_beat_q, hdr_fire;
    logic [SEQ_W-1:0]     seq_q;

    assign hdr_fire = (state_q == ST_HDR) && pkt_ready;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|req) state_d = ST_ARB;
`ifdef ARB_HEADER_EN
            ST_ARB:    state_d = grant_any ? ST_HDR : ST_IDLE;
            ST_HDR:    if (hdr_fire && hdr_cnt == HDR_CNT_W'(HDR_LEN - 1)) state_d = ST_STREAM;
`else
            ST_ARB:    state_d = grant_any ? ST_STREAM : ST_IDLE;
            ST_HDR:    state_d = ST_IDLE;
`endif
            ST_STREAM: if (last_rd) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_cnt     <= '0;
            rr_ptr     <= '0;
            ch_q       <= '0;
            sel_q      <= '0;
            beat_q     <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            underrun_q <= 1'b0;
`ifdef ARB_HEADER_EN
            hdr_cnt    <= '0;
            hdr_q      <= '0;
            hdr_beat_q <= 1'b0;
            seq_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            eop_q   <= last_rd;
`ifdef ARB_HEADER_EN
            beat_q     <= rd_fire || hdr_fire;
            sop_q      <= hdr_fire && (hdr_cnt == '0);
            hdr_beat_q <= hdr_fire;
            if (hdr_fire) begin
                hdr_q   <= hdr_byte(hdr_cnt, 4'(ch_q), 24'(seq_q));
                hdr_cnt <= hdr_cnt + 1'b1;
            end
            if (state_q == ST_DONE) seq_q <= seq_q + 1'b1;
`else
            beat_q <= rd_fire;
            sop_q  <= rd_fire && (rd_cnt == '0);
`endif
            if (state_q == ST_ARB && grant_any) begin
                ch_q   <= grant_idx;
                sel_q  <= grant;
                rr_ptr <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == ST_DONE)  rd_cnt <= '0;
            else if (rd_fire)        rd_cnt <= rd_cnt + 1'b1;
            if (state_q == ST_STREAM && ch_rdempty[ch_q]) underrun_q <= 1'b1;
        end
    end

    // FIFO dout already holds the byte one cycle after rdreq, so only the mux sits here.
    always_comb begin
        pkt_data = '0;
        if (beat_q) pkt_data = ch_dout[ch_q*DATA_W +: DATA_W];
`ifdef ARB_HEADER_EN
        if (hdr_beat_q) pkt_data = DATA_W'(hdr_q);
`endif
    end

    assign pkt_valid    = beat_q;
    assign pkt_sop      = sop_q;
    assign pkt_eop      = eop_q;
    assign pkt_ch       = ch_q;
    assign underrun_err = underrun_q;

endmodule

// File: tb/tb_adc_block_arbiter.sv
// Directed bench for adc_block_arbiter with two behavioural non-FWFT FIFOs; header test under ARB_HEADER_EN.
module tb_adc_block_arbiter;

    localparam int BB = 256;
`ifdef ARB_HEADER_EN
    localparam int HL = 4;
`else
    localparam int HL = 0;
`endif
    localparam int BL = BB + HL;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ch_enable, ch_block_rdy, ch_rdempty, ch_rdreq;
    logic [15:0] ch_dout;
    logic        pkt_ready, pkt_valid, pkt_sop, pkt_eop, underrun_err;
    logic [7:0]  pkt_data;
    logic [0:0]  pkt_ch;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adc_block_arbiter #(.N_CH(2), .DATA_W(8), .BLOCK_BYTES(BB), .SEQ_W(24)) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_enable    (ch_enable),
        .ch_block_rdy (ch_block_rdy),
        .ch_rdempty   (ch_rdempty),
        .ch_dout      (ch_dout),
        .ch_rdreq     (ch_rdreq),
        .pkt_ready    (pkt_ready),
        .pkt_valid    (pkt_valid),
        .pkt_data     (pkt_data),
        .pkt_sop      (pkt_sop),
        .pkt_eop      (pkt_eop),
        .pkt_ch       (pkt_ch),
        .underrun_err (underrun_err)
    );

    // FIFO models: popped bytes are logged per channel as the expected output order.
    logic [7:0] fifo0[$], fifo1[$], popq0[$], popq1[$];
    logic [7:0] dout0 = 8'h00, dout1 = 8'h00, t0, t1;
    int  pop0 = 0, hold0 = 0, cyc = 0;
    bit  inject = 1'b0;
    assign ch_dout = {dout1, dout0};

    always @(posedge clk) begin
        cyc++;
        if (ch_rdreq[0]) begin
            if (fifo0.size() > 0) begin
                t0 = fifo0.pop_front();
                dout0 <= t0;
                popq0.push_back(t0);
            end
            pop0++;
            if (inject && pop0 == 100) hold0 = 5;
        end else if (hold0 > 0) begin
            hold0--;
        end
        if (ch_rdreq[1]) begin
            if (fifo1.size() > 0) begin
                t1 = fifo1.pop_front();
                dout1 <= t1;
                popq1.push_back(t1);
            end
        end
    end

    always @(negedge clk) begin
        ch_block_rdy <= {fifo1.size() >= BB, fifo0.size() >= BB};
        ch_rdempty   <= {fifo1.size() == 0, (fifo0.size() == 0) || (hold0 != 0)};
    end

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [0:0] ch;
        int         cyc;
    } beat_t;
    beat_t cap[$];
    beat_t mb;

    always @(negedge clk) begin
        if (pkt_valid === 1'b1) begin
            mb.d = pkt_data; mb.sop = pkt_sop; mb.eop = pkt_eop; mb.ch = pkt_ch; mb.cyc = cyc;
            cap.push_back(mb);
        end
    end

    task automatic fill(input int c, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            if (c == 0) fifo0.push_back(base + 8'(i));
            else        fifo1.push_back(base + 8'(i));
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
    endtask

    function automatic logic [7:0] next_byte(input int c);
        logic [7:0] v = 8'hxx;
        if (c == 0 && popq0.size() > 0) v = popq0.pop_front();
        if (c == 1 && popq1.size() > 0) v = popq1.pop_front();
        return v;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({pkt_valid, pkt_sop, pkt_eop, pkt_ch, underrun_err, ch_rdreq, pkt_data} !== 15'h0)
            begin errors++; $display("FAIL reset_outputs: got %h required 0",
                {pkt_valid, pkt_sop, pkt_eop, pkt_ch, underrun_err, ch_rdreq, pkt_data}); end
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({pkt_valid, ch_rdreq} !== 3'b000)
            begin errors++; $display("FAIL idle_no_request: got %b required 000", {pkt_valid, ch_rdreq}); end
    endtask

    task automatic test_single;
        logic [10:0] obs, exp;
        cap.delete(); popq0.delete(); popq1.delete();
        fill(0, BB, 8'h00);
        wait_beats(BL, 2000);
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (cap.size() != BL) begin errors++; $display("FAIL single_count: got %0d required %0d", cap.size(), BL); end
        for (int i = 0; i < BL; i++) begin
            obs = {cap[i].sop, cap[i].eop, cap[i].ch, (i < HL) ? 8'h00 : cap[i].d};
            exp = {i == 0, i == BL - 1, 1'b0, (i < HL) ? 8'h00 : 8'(i - HL)};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL single_beat%0d: got %h required %h", i, obs, exp); end
        end
        checks++;
        if (cap[BL-1].cyc - cap[0].cyc != BL - 1)
            begin errors++; $display("FAIL single_no_bubbles: span %0d required %0d", cap[BL-1].cyc - cap[0].cyc, BL - 1); end
    endtask

    task automatic test_alternate;
        logic [10:0] obs, exp;
        int c, s;
        cap.delete(); popq0.delete(); popq1.delete();
        fill(0, 2 * BB, 8'h40);
        fill(1, 2 * BB, 8'hC0);
        wait_beats(4 * BL, 6000);
        checks++;
        if (cap.size() < 4 * BL) begin errors++; $display("FAIL alt_timeout: got %0d required %0d", cap.size(), 4 * BL); end
        for (int b = 0; b < 4; b++) begin
            c = (b % 2 == 0) ? 1 : 0;  // pointer sits at ch1 after the single ch0 block
            s = b * BL;
            for (int i = 0; i < BL; i++) begin
                obs = {cap[s+i].sop, cap[s+i].eop, cap[s+i].ch, (i < HL) ? 8'h00 : cap[s+i].d};
                exp = {i == 0, i == BL - 1, 1'(c), (i < HL) ? 8'h00 : next_byte(c)};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL alt_blk%0d_beat%0d: got %h required %h", b, i, obs, exp); end
            end
            if (b > 0) begin
                checks++;
                if (cap[s].cyc - cap[s-1].cyc != 4)
                    begin errors++; $display("FAIL alt_gap%0d: got %0d required 4", b, cap[s].cyc - cap[s-1].cyc); end
            end
        end
    endtask

    task automatic test_ready_toggle;
        logic [10:0] obs, exp;
        int k = 0;
        cap.delete(); popq0.delete(); popq1.delete();
        fill(0, BB, 8'h11);
        while (cap.size() < BL && k < 3000) begin
            @(negedge clk);
            pkt_ready = ~pkt_ready;
            #1;
            if (!pkt_ready) begin
                checks++;
                if (ch_rdreq !== 2'b00) begin errors++; $display("FAIL toggle_rdreq_stall: got %b required 00", ch_rdreq); end
            end
            k++;
        end
        pkt_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (cap.size() != BL) begin errors++; $display("FAIL toggle_count: got %0d required %0d", cap.size(), BL); end
        for (int i = 0; i < BL; i++) begin
            obs = {cap[i].sop, cap[i].eop, cap[i].ch, (i < HL) ? 8'h00 : cap[i].d};
            exp = {i == 0, i == BL - 1, 1'b0, (i < HL) ? 8'h00 : next_byte(0)};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL toggle_beat%0d: got %h required %h", i, obs, exp); end
        end
    endtask

    task automatic test_underrun;
        logic [10:0] obs, exp;
        checks++;
        if (underrun_err !== 1'b0) begin errors++; $display("FAIL underrun_pre: got %b required 0", underrun_err); end
        cap.delete(); popq0.delete(); popq1.delete();
        @(negedge clk);
        pop0 = 0; inject = 1'b1;
        fill(0, BB, 8'h23);
        wait_beats(BL, 3000);
        inject = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (underrun_err !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b required 1", underrun_err); end
        checks++;
        if (cap.size() != BL) begin errors++; $display("FAIL underrun_count: got %0d required %0d", cap.size(), BL); end
        checks++;
        if (cap[HL+100].cyc - cap[HL+99].cyc != 6)
            begin errors++; $display("FAIL underrun_stall: got %0d required 6", cap[HL+100].cyc - cap[HL+99].cyc); end
        for (int i = 0; i < BL; i++) begin
            obs = {cap[i].sop, cap[i].eop, cap[i].ch, (i < HL) ? 8'h00 : cap[i].d};
            exp = {i == 0, i == BL - 1, 1'b0, (i < HL) ? 8'h00 : 8'h23 + 8'(i - HL)};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL underrun_beat%0d: got %h required %h", i, obs, exp); end
        end
    endtask

    task automatic test_mid_reset;
        logic [10:0] obs, exp;
        int s, c, held;
        cap.delete(); popq0.delete(); popq1.delete();
        fill(0, BB, 8'h37);
        wait_beats(50, 2000);
        checks++;
        if (cap.size() < 50) begin errors++; $display("FAIL midrst_timeout: got %0d required 50", cap.size()); end
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({pkt_valid, pkt_sop, pkt_eop, pkt_ch, underrun_err, ch_rdreq, pkt_data} !== 15'h0)
            begin errors++; $display("FAIL midrst_outputs: got %h required 0",
                {pkt_valid, pkt_sop, pkt_eop, pkt_ch, underrun_err, ch_rdreq, pkt_data}); end
        held = fifo0.size();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (fifo0.size() != held) begin errors++; $display("FAIL midrst_fifo_kept: got %0d required %0d", fifo0.size(), held); end
        popq0.delete(); popq1.delete(); cap.delete();
        fill(0, BB, 8'h55);
        fill(1, BB, 8'h99);
        @(negedge clk); reset = 1'b0;
        wait_beats(2 * BL, 4000);
        checks++;
        if (cap.size() < 2 * BL) begin errors++; $display("FAIL midrst_post_timeout: got %0d required %0d", cap.size(), 2 * BL); end
        for (int b = 0; b < 2; b++) begin
            c = b;
            s = b * BL;
            for (int i = 0; i < BL; i++) begin
                obs = {cap[s+i].sop, cap[s+i].eop, cap[s+i].ch, (i < HL) ? 8'h00 : cap[s+i].d};
                exp = {i == 0, i == BL - 1, 1'(c), (i < HL) ? 8'h00 : next_byte(c)};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL midrst_blk%0d_beat%0d: got %h required %h", b, i, obs, exp); end
            end
        end
    endtask

`ifdef ARB_HEADER_EN
    task automatic test_header;
        logic [7:0] hexp [8];
        logic [10:0] obs, exp;
        int s;
        hexp[0] = 8'h01; hexp[1] = 8'hFF; hexp[2] = 8'hFF; hexp[3] = 8'hFF;
        hexp[4] = 8'h01; hexp[5] = 8'h00; hexp[6] = 8'h00; hexp[7] = 8'h00;
        repeat (10) @(negedge clk);
        dut.seq_q = 24'hFFFFFF;
        cap.delete(); popq0.delete(); popq1.delete();
        fill(1, 2 * BB, 8'h70);
        wait_beats(2 * BL, 4000);
        checks++;
        if (cap.size() < 2 * BL) begin errors++; $display("FAIL hdr_timeout: got %0d required %0d", cap.size(), 2 * BL); end
        for (int b = 0; b < 2; b++) begin
            s = b * BL;
            for (int i = 0; i < BL; i++) begin
                obs = {cap[s+i].sop, cap[s+i].eop, cap[s+i].ch, cap[s+i].d};
                exp = {i == 0, i == BL - 1, 1'b1, (i < HL) ? hexp[b*4+i] : next_byte(1)};
                checks++;
                if (obs !== exp) begin errors++; $display("FAIL hdr_blk%0d_beat%0d: got %h required %h", b, i, obs, exp); end
            end
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        ch_enable = 2'b11;
        pkt_ready = 1'b1;
        test_reset();
        test_single();
        test_alternate();
        test_ready_toggle();
        test_underrun();
        test_mid_reset();
`ifdef ARB_HEADER_EN
        test_header();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
